// File: rtl/roll_scheduler_if.sv
// Key/random inputs and display outputs of the roll scheduler, bundled as one port.
interface roll_scheduler_if;
    logic       i_start;
    logic       i_mem;
    logic [3:0] i_rand;
    logic [3:0] o_value;
    logic [3:0] o_mem_value;
    logic       o_busy;
    logic       o_sample;
    logic       o_done;

    modport slave (
        input  i_start, i_mem, i_rand,
        output o_value, o_mem_value, o_busy, o_sample, o_done
    );

    modport master (
        output i_start, i_mem, i_rand,
        input  o_value, o_mem_value, o_busy, o_sample, o_done
    );
endinterface

// File: rtl/roll_scheduler.sv
// Dice roll sequencer: samples a random nibble at ever-longer intervals, then
// freezes on the final value; one memory slot holds a recalled result.
module roll_scheduler #(
    parameter int unsigned P_FIRST_INTERVAL = 2_500_000,
    parameter int unsigned P_STEPS          = 16,
    parameter int unsigned P_CNT_W          = 28
) (
    input  logic              i_clk,
    input  logic              i_rst,
    roll_scheduler_if.slave   bus
);

    localparam int unsigned STEP_W = (P_STEPS > 1) ? $clog2(P_STEPS) : 1;
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(P_STEPS - 1);
    localparam logic [P_CNT_W-1:0] FIRST     = P_CNT_W'(P_FIRST_INTERVAL);
    localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);
    localparam logic [P_CNT_W:0]   CNT_MAX   = {1'b0, {P_CNT_W{1'b1}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic [P_CNT_W-1:0]  timer_q;
    logic [P_CNT_W-1:0]  interval_q;
    logic [STEP_W-1:0]   step_q;
    logic [3:0]          value_q;
    logic [3:0]          mem_value_q;
    logic                busy_q;
    logic                sample_q;
    logic                done_q;

    logic [P_CNT_W-1:0]  grow_d;
    logic [P_CNT_W:0]    sum_d;
    logic [P_CNT_W-1:0]  interval_d;
    logic                event_d;

    // Next interval: grow by a quarter (at least one cycle), saturating at full scale.
    always_comb begin
        grow_d     = interval_q >> 2;
        sum_d      = {1'b0, interval_q};
        interval_d = interval_q;
        if (grow_d == '0) begin
            grow_d = CNT_ONE;
        end else begin
            grow_d = interval_q >> 2;
        end
        sum_d = {1'b0, interval_q} + {1'b0, grow_d};
        if (sum_d > CNT_MAX) begin
            interval_d = {P_CNT_W{1'b1}};
        end else begin
            interval_d = sum_d[P_CNT_W-1:0];
        end
        event_d = (timer_q == (interval_q - CNT_ONE));
    end

    // Roll state machine with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            interval_q  <= FIRST;
            step_q      <= '0;
            value_q     <= 4'h0;
            mem_value_q <= 4'h0;
            busy_q      <= 1'b0;
            sample_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        interval_q <= FIRST;
                        timer_q    <= '0;
                        step_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end else if (bus.i_mem) begin
                        mem_value_q <= value_q;
                    end
                end
                S_RUN: begin
                    // A restart discards any event landing in the same cycle.
                    if (bus.i_start) begin
                        interval_q <= FIRST;
                        timer_q    <= '0;
                        step_q     <= '0;
                    end else if (event_d) begin
                        value_q    <= bus.i_rand;
                        sample_q   <= 1'b1;
                        timer_q    <= '0;
                        step_q     <= step_q + STEP_W'(1);
                        interval_q <= interval_d;
                        if (step_q == LAST_STEP) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_value     = value_q;
    assign bus.o_mem_value = mem_value_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_sample    = sample_q;
    assign bus.o_done      = done_q;

endmodule

// File: doc/roll_scheduler.md
# roll_scheduler

Sequencing controller for the dice-style random-number display path. On a start request it samples the free-running 4-bit random source at progressively longer intervals, so the hex display visibly "spins and slows down". After a fixed number of updates it freezes on the final value and keeps a single memory slot for recall. It sits between the debounced key pulses and the seven-segment decoders, in place of ad-hoc sampling logic in the top-level datapath.

## Interface
- P_FIRST_INTERVAL, 2_500_000, cycles between start and the first sample (≥1; 50 ms at 50 MHz)
- P_STEPS, 16, number of samples per roll (≥1)
- P_CNT_W, 28, width of the interval and timer registers

- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse from the debouncer; starts or restarts a roll
- i_mem  in  1  one-cycle pulse; copies o_value into o_mem_value (IDLE only)
- i_rand  in  4  free-running random value, sampled combinationally
- o_value  out  4  currently displayed value
- o_mem_value  out  4  stored value
- o_busy  out  1  high while a roll is in progress
- o_sample  out  1  one-cycle pulse; o_value updated this cycle
- o_done  out  1  one-cycle pulse; roll finished, o_value final

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset: state=IDLE, o_value=0, o_mem_value=0, o_busy=0, o_sample=0, o_done=0, timer=0, step=0, interval=P_FIRST_INTERVAL.
- IDLE:
  - i_start: interval<=P_FIRST_INTERVAL, timer<=0, step<=0, state<=RUN, o_busy<=1.
  - i_mem alone: o_mem_value<=o_value.
  - i_start and i_mem together: start wins; mem ignored.
- RUN, each cycle:
  - timer != interval-1: timer<=timer+1.
  - timer == interval-1 ("event"): o_value<=i_rand, o_sample<=1, timer<=0, step<=step+1, interval<=interval+max(interval>>2,1), saturating at 2^P_CNT_W-1.
  - Event with step==P_STEPS-1: additionally o_done<=1, o_busy<=0, state<=IDLE.
- i_start in RUN: restart exactly as from IDLE. o_value is unchanged, and a coincident event is discarded (no o_sample).
- i_mem in RUN: ignored.
- o_sample and o_done default to 0 every cycle unless set as above.
- i_rst mid-roll: all state returns to reset values on the next edge. No sample or done pulse is emitted.

## Timing
- i_start high in cycle 0 → o_busy=1 from cycle 1, timer=0 in cycle 1.
- The k-th event (k=1..P_STEPS) occurs in the cycle where timer has counted interval_k cycles. o_sample and the new o_value are visible in the following cycle.
- With P_FIRST_INTERVAL=N, the first o_sample is visible in cycle N+1.
- The final o_sample, o_done and o_busy=0 all become visible in the same cycle.
- A new i_start is accepted in the cycle o_done is high.
- o_mem_value updates one cycle after i_mem.

## Test plan
- Reset: assert i_rst for 2 cycles mid-operation → all outputs 0, state IDLE, no o_sample/o_done afterwards.
- Basic roll, P_FIRST_INTERVAL=4, P_STEPS=3, i_start in cycle 0, i_rand changing every cycle → o_sample in cycles 5, 10 and 16; each o_value equals i_rand from cycles 4, 9 and 15; o_done=1 and o_busy=0 in cycle 16.
- Restart: same parameters, second i_start in cycle 7 → sample schedule restarts, o_sample at cycles 12, 17 and 23, o_done at 23. o_value at cycles 7–11 holds the cycle-5 sample.
- Memory: after a roll ends with o_value=0xA, pulse i_mem → o_mem_value=0xA next cycle. An i_mem pulse during RUN leaves o_mem_value unchanged.
- Simultaneous keys: i_start and i_mem in the same IDLE cycle → roll starts, o_mem_value unchanged.
- Saturation: P_CNT_W=4, P_FIRST_INTERVAL=12, P_STEPS=4 → intervals 12, 15, 15, 15; no wrap to small values.
